// File: rtl/lcd_pkg.sv
// Types and constants shared by the HD44780 4-bit byte writer and its bench.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP_H,
    ST_EHIGH_H,
    ST_HOLD_H,
    ST_SETUP_L,
    ST_EHIGH_L,
    ST_HOLD_L,
    ST_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
  // Return Home ignores bit 0, so 0x03 executes with the same long delay.
  localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

  localparam int unsigned DEF_SETUP_CYC      = 2;
  localparam int unsigned DEF_E_HIGH_CYC     = 25;
  localparam int unsigned DEF_HOLD_CYC       = 50;
  localparam int unsigned DEF_CMD_DELAY_CYC  = 2500;
  localparam int unsigned DEF_LONG_DELAY_CYC = 82000;

  localparam int RS_BIT  = 4;
  localparam int NIB_MSB = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [4:0] pack_pins(input logic rs, input logic [3:0] nibble);
    logic [4:0] pins;
    pins             = '0;
    pins[RS_BIT]     = rs;
    pins[NIB_MSB:0]  = nibble;
    return pins;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives LCD_D/LCD_E for one command or data byte per handshake, with setup,
// enable, hold and post-write execution delays for an HD44780 in 4-bit mode.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
  parameter int unsigned E_HIGH_CYC     = DEF_E_HIGH_CYC,
  parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
  parameter int unsigned CMD_DELAY_CYC  = DEF_CMD_DELAY_CYC,
  parameter int unsigned LONG_DELAY_CYC = DEF_LONG_DELAY_CYC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       wr_nibble_only,
  output logic       busy,
  output logic [4:0] LCD_D,
  output logic       LCD_E
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, E_HIGH_CYC), max_u(HOLD_CYC, CMD_DELAY_CYC)),
                                          LONG_DELAY_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // The counter is loaded with N-1 so a state lasts exactly N cycles ending at zero.
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EHIGH_LD = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t CMD_LD   = cnt_t'(CMD_DELAY_CYC - 1);
  localparam cnt_t LONG_LD  = cnt_t'(LONG_DELAY_CYC - 1);

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       nib_q, nib_d;
  logic [4:0] lcd_d_q, lcd_d_d;
  logic       lcd_e_q, lcd_e_d;
  logic       long_wait;
  logic       cnt_done;

  assign cnt_done  = (cnt_q == '0);
  assign long_wait = nib_q ||
                     (!rs_q && ((data_q == LCD_CMD_CLEAR) || (data_q == LCD_CMD_HOME) ||
                                (data_q == LCD_CMD_HOME_ALT)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - cnt_t'(1);
    rs_d    = rs_q;
    data_d  = data_q;
    nib_d   = nib_q;
    lcd_d_d = lcd_d_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          rs_d   = wr_rs;
          data_d = wr_data;
          nib_d  = wr_nibble_only;
          cnt_d  = SETUP_LD;
          if (wr_nibble_only) begin
            state_d = ST_SETUP_L;
            lcd_d_d = pack_pins(wr_rs, wr_data[3:0]);
          end else begin
            state_d = ST_SETUP_H;
            lcd_d_d = pack_pins(wr_rs, wr_data[7:4]);
          end
        end
      end
      ST_SETUP_H: if (cnt_done) begin state_d = ST_EHIGH_H; cnt_d = EHIGH_LD; end
      ST_EHIGH_H: if (cnt_done) begin state_d = ST_HOLD_H;  cnt_d = HOLD_LD;  end
      ST_HOLD_H: begin
        if (cnt_done) begin
          state_d = ST_SETUP_L;
          cnt_d   = SETUP_LD;
          lcd_d_d = pack_pins(rs_q, data_q[3:0]);
        end
      end
      ST_SETUP_L: if (cnt_done) begin state_d = ST_EHIGH_L; cnt_d = EHIGH_LD; end
      ST_EHIGH_L: if (cnt_done) begin state_d = ST_HOLD_L;  cnt_d = HOLD_LD;  end
      ST_HOLD_L: begin
        if (cnt_done) begin
          state_d = ST_WAIT;
          cnt_d   = long_wait ? LONG_LD : CMD_LD;
        end
      end
      ST_WAIT: if (cnt_done) state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // E follows the next state so the registered strobe lines up with EHIGH_*.
    lcd_e_d = (state_d == ST_EHIGH_H) || (state_d == ST_EHIGH_L);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      nib_q   <= 1'b0;
      lcd_d_q <= '0;
      lcd_e_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      nib_q   <= nib_d;
      lcd_d_q <= lcd_d_d;
      lcd_e_q <= lcd_e_d;
    end
  end

  assign wr_ready = !RST && (state_q == ST_IDLE);
  assign busy     = !RST && (state_q != ST_IDLE);
  assign LCD_D    = lcd_d_q;
  assign LCD_E    = lcd_e_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer using shortened timing so long waits stay cheap.
module tb_lcd_byte_writer;

  localparam int S    = 2;
  localparam int EH   = 5;
  localparam int H    = 4;
  localparam int CMD  = 20;
  localparam int LONG = 60;
  localparam int PH   = 11;     // 2 + 5 + 4
  localparam int T_BYTE = 42;   // 2*11 + 20
  localparam int T_LONG = 82;   // 2*11 + 60
  localparam int T_NIB  = 71;   // 11 + 60
  localparam int MAX_T  = 100;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_nibble_only = 1'b0;
  logic       busy;
  logic [4:0] LCD_D;
  logic       LCD_E;

  int n_checks = 0;
  int n_fails  = 0;
  int e_pulses = 0;

  logic [5:0] obs_pins [0:MAX_T];
  logic       obs_rdy  [0:MAX_T];
  logic       obs_busy [0:MAX_T];
  int         obs_len;

  lcd_byte_writer #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H), .CMD_DELAY_CYC(CMD), .LONG_DELAY_CYC(LONG)
  ) dut (
    .CLK(CLK), .RST(RST), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_nibble_only(wr_nibble_only), .busy(busy), .LCD_D(LCD_D), .LCD_E(LCD_E)
  );

  always #5 CLK = ~CLK;

  // Expected {E, RS, nibble} c cycles after the acceptance edge.
  function automatic logic [5:0] model_pins(input logic rs, input logic [7:0] data, input logic nib, input int c);
    int p;
    logic [3:0] nv;
    if (nib) begin p = c; nv = data[3:0]; end
    else if (c < PH) begin p = c; nv = data[7:4]; end
    else begin p = c - PH; nv = data[3:0]; end
    return {(p >= S) && (p < S + EH), rs, nv};
  endfunction

  // Counts E pulses, checks their width and that LCD_D holds still while E is high.
  logic       prev_e = 1'b0;
  logic [4:0] prev_d = '0;
  int         e_len  = 0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_e = 1'b0;
      e_len  = 0;
    end else begin
      if (LCD_E) begin
        if (prev_e) begin
          n_checks++;
          if (LCD_D !== prev_d) begin
            n_fails++;
            $display("[TB] FAIL lcd_d_stable_e_high: LCD_D=%h, required %h", LCD_D, prev_d);
          end
        end else begin
          e_pulses++;
        end
        e_len++;
      end else if (prev_e) begin
        n_checks++;
        if (e_len != EH) begin
          n_fails++;
          $display("[TB] FAIL e_pulse_width: %0d cycles, required %0d", e_len, EH);
        end
        e_len = 0;
      end
      prev_e = LCD_E;
      prev_d = LCD_D;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits for ready, performs one write and records pins until wr_ready returns.
  task automatic send_write(input logic rs, input logic [7:0] data, input logic nib,
                            input logic hold_valid, input int pulse_at, output int waited);
    waited = 0;
    while (!wr_ready && waited < 200) begin
      @(posedge CLK); #1;
      waited++;
    end
    wr_rs = rs; wr_data = data; wr_nibble_only = nib; wr_valid = 1'b1;
    @(posedge CLK); #1;
    if (!hold_valid) wr_valid = 1'b0;
    obs_len = -1;
    for (int c = 0; c <= MAX_T; c++) begin
      obs_pins[c] = {LCD_E, LCD_D};
      obs_rdy[c]  = wr_ready;
      obs_busy[c] = busy;
      if (wr_ready) begin
        obs_len = c;
        break;
      end
      if (c == pulse_at) begin
        wr_valid = 1'b1; wr_rs = ~rs; wr_data = 8'hFF; wr_nibble_only = 1'b0;
      end else if (c == pulse_at + 1) begin
        wr_valid = 1'b0;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) begin @(posedge CLK); #1; end
    n_checks++; if (LCD_E !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_lcd_e: %b, required 0", LCD_E); end
    n_checks++; if (LCD_D !== 5'h00) begin n_fails++; $display("[TB] FAIL reset_lcd_d: %h, required 00", LCD_D); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready: %b, required 0", wr_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: %b, required 0", busy); end
    RST = 1'b0;
    @(posedge CLK); #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL release_ready: %b, required 1", wr_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL release_busy: %b, required 0", busy); end
  endtask

  task automatic test_data_write();
    int waited, bad, first_bad, e0;
    e0 = e_pulses;
    send_write(1'b1, 8'h48, 1'b0, 1'b0, -1, waited);
    n_checks++; if (obs_len !== T_BYTE) begin n_fails++; $display("[TB] FAIL data_len: %0d cycles, required %0d", obs_len, T_BYTE); end
    n_checks++; if (obs_pins[0] !== 6'h14) begin n_fails++; $display("[TB] FAIL data_setup_h: %h, required 14", obs_pins[0]); end
    n_checks++; if (obs_pins[2] !== 6'h34) begin n_fails++; $display("[TB] FAIL data_ehigh_h: %h, required 34", obs_pins[2]); end
    n_checks++; if (obs_pins[PH] !== 6'h18) begin n_fails++; $display("[TB] FAIL data_setup_l: %h, required 18", obs_pins[PH]); end
    n_checks++; if (obs_pins[PH+S] !== 6'h38) begin n_fails++; $display("[TB] FAIL data_ehigh_l: %h, required 38", obs_pins[PH+S]); end
    bad = 0; first_bad = -1;
    for (int c = 0; c <= T_BYTE; c++)
      if (obs_pins[c] !== model_pins(1'b1, 8'h48, 1'b0, c) || obs_rdy[c] !== (c == T_BYTE) ||
          obs_busy[c] !== (c != T_BYTE)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    n_checks++; if (bad != 0) begin n_fails++; $display("[TB] FAIL data_trace: %0d bad cycles (first %0d), required 0", bad, first_bad); end
    n_checks++; if (e_pulses - e0 != 2) begin n_fails++; $display("[TB] FAIL data_e_count: %0d, required 2", e_pulses - e0); end
  endtask

  task automatic test_command();
    int waited, bad, first_bad;
    send_write(1'b0, 8'h01, 1'b0, 1'b0, -1, waited);
    n_checks++; if (obs_len !== T_LONG) begin n_fails++; $display("[TB] FAIL clear_len: %0d cycles, required %0d", obs_len, T_LONG); end
    n_checks++; if (obs_pins[0] !== 6'h00) begin n_fails++; $display("[TB] FAIL clear_high_nib: %h, required 00", obs_pins[0]); end
    n_checks++; if (obs_pins[PH] !== 6'h01) begin n_fails++; $display("[TB] FAIL clear_low_nib: %h, required 01", obs_pins[PH]); end
    bad = 0; first_bad = -1;
    for (int c = 0; c <= T_LONG; c++)
      if (obs_pins[c] !== model_pins(1'b0, 8'h01, 1'b0, c) || obs_rdy[c] !== (c == T_LONG)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    n_checks++; if (bad != 0) begin n_fails++; $display("[TB] FAIL clear_trace: %0d bad cycles (first %0d), required 0", bad, first_bad); end
  endtask

  task automatic test_wait_select();
    logic       t_rs   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] t_data [6] = '{8'h02, 8'h03, 8'h04, 8'h00, 8'h01, 8'h28};
    int         t_len  [6] = '{T_LONG, T_LONG, T_BYTE, T_BYTE, T_BYTE, T_BYTE};
    int waited;
    for (int i = 0; i < 6; i++) begin
      send_write(t_rs[i], t_data[i], 1'b0, 1'b0, -1, waited);
      n_checks++;
      if (obs_len !== t_len[i]) begin
        n_fails++;
        $display("[TB] FAIL wait_len rs=%b data=%h: %0d cycles, required %0d", t_rs[i], t_data[i], obs_len, t_len[i]);
      end
    end
  endtask

  task automatic test_nibble_only();
    int waited, bad, first_bad, e0;
    e0 = e_pulses;
    send_write(1'b0, 8'h53, 1'b1, 1'b0, 30, waited);
    n_checks++; if (obs_len !== T_NIB) begin n_fails++; $display("[TB] FAIL nibble_len: %0d cycles, required %0d", obs_len, T_NIB); end
    n_checks++; if (obs_pins[0] !== 6'h03) begin n_fails++; $display("[TB] FAIL nibble_setup: %h, required 03", obs_pins[0]); end
    n_checks++; if (obs_pins[S] !== 6'h23) begin n_fails++; $display("[TB] FAIL nibble_ehigh: %h, required 23", obs_pins[S]); end
    bad = 0; first_bad = -1;
    for (int c = 0; c <= T_NIB; c++)
      if (obs_pins[c] !== model_pins(1'b0, 8'h53, 1'b1, c) || obs_rdy[c] !== (c == T_NIB)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    n_checks++; if (bad != 0) begin n_fails++; $display("[TB] FAIL nibble_trace: %0d bad cycles (first %0d), required 0", bad, first_bad); end
    repeat (3) begin @(posedge CLK); #1; end
    n_checks++; if (wr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL ignored_valid_ready: %b, required 1", wr_ready); end
    n_checks++; if (e_pulses - e0 != 1) begin n_fails++; $display("[TB] FAIL nibble_e_count: %0d, required 1", e_pulses - e0); end
  endtask

  task automatic test_back_to_back();
    int waited, bad, first_bad, e0;
    e0 = e_pulses;
    send_write(1'b1, 8'h48, 1'b0, 1'b1, -1, waited);
    n_checks++; if (obs_len !== T_BYTE) begin n_fails++; $display("[TB] FAIL b2b_first_len: %0d cycles, required %0d", obs_len, T_BYTE); end
    send_write(1'b1, 8'h69, 1'b0, 1'b0, -1, waited);
    n_checks++; if (waited != 0) begin n_fails++; $display("[TB] FAIL b2b_gap: %0d idle cycles, required 0", waited); end
    n_checks++; if (obs_pins[0] !== 6'h16) begin n_fails++; $display("[TB] FAIL b2b_second_high: %h, required 16", obs_pins[0]); end
    bad = 0; first_bad = -1;
    for (int c = 0; c <= T_BYTE; c++)
      if (obs_pins[c] !== model_pins(1'b1, 8'h69, 1'b0, c) || obs_rdy[c] !== (c == T_BYTE)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    n_checks++; if (bad != 0) begin n_fails++; $display("[TB] FAIL b2b_trace: %0d bad cycles (first %0d), required 0", bad, first_bad); end
    n_checks++; if (e_pulses - e0 != 4) begin n_fails++; $display("[TB] FAIL b2b_e_count: %0d, required 4", e_pulses - e0); end
  endtask

  task automatic test_reset_mid_write();
    int waited, bad, first_bad;
    waited = 0;
    while (!wr_ready && waited < 200) begin @(posedge CLK); #1; waited++; end
    wr_rs = 1'b1; wr_data = 8'h48; wr_nibble_only = 1'b0; wr_valid = 1'b1;
    @(posedge CLK); #1;
    wr_valid = 1'b0;
    repeat (PH + S + 1) begin @(posedge CLK); #1; end
    n_checks++; if (LCD_E !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_ehigh_l: LCD_E=%b, required 1", LCD_E); end
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (LCD_E !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_reset_e: %b, required 0", LCD_E); end
    n_checks++; if (LCD_D !== 5'h00) begin n_fails++; $display("[TB] FAIL mid_reset_d: %h, required 00", LCD_D); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_reset_busy: %b, required 0", busy); end
    RST = 1'b0;
    @(posedge CLK); #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_release_ready: %b, required 1", wr_ready); end
    send_write(1'b1, 8'h69, 1'b0, 1'b0, -1, waited);
    bad = 0; first_bad = -1;
    for (int c = 0; c <= T_BYTE; c++)
      if (obs_pins[c] !== model_pins(1'b1, 8'h69, 1'b0, c) || obs_rdy[c] !== (c == T_BYTE)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    n_checks++; if (obs_len !== T_BYTE || bad != 0) begin
      n_fails++;
      $display("[TB] FAIL post_reset_write: len %0d with %0d bad cycles, required len %0d and 0", obs_len, bad, T_BYTE);
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_command();
    test_wait_select();
    test_nibble_only();
    test_back_to_back();
    test_reset_mid_write();
    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
Physical-layer stage for the HD44780-style character LCD in 4-bit mode. Sits directly downstream of the LCD init/text sequencer: takes one byte (command or data) per valid/ready handshake and drives LCD_D/LCD_E with correct setup, enable-pulse, hold and post-write execution delays. The sequencer only decides what to send; this block decides when pins toggle.

Parameters:
SETUP_CYC, 2, cycles RS/data stable before E rises (≥1)
E_HIGH_CYC, 25, cycles E held high per nibble (≥1)
HOLD_CYC, 50, cycles E low with data held after each nibble (≥1)
CMD_DELAY_CYC, 2500, execution wait after a normal byte (≥1)
LONG_DELAY_CYC, 82000, execution wait after clear/home commands and nibble-only writes (≥1)

Ports:
CLK  in  1  system clock (50 MHz)
RST  in  1  synchronous, active-high reset
wr_valid  in  1  upstream has a write pending
wr_ready  out  1  block idle, accepts write this cycle
wr_rs  in  1  0 = command, 1 = data
wr_data  in  8  byte to write
wr_nibble_only  in  1  send only wr_data[3:0] as a single nibble (init sequence)
busy  out  1  transaction in progress (= ~wr_ready outside reset)
LCD_D  out  5  [3:0] data nibble, [4] RS
LCD_E  out  1  enable strobe

Behaviour:
- Single clock CLK; reset is synchronous and active-high on RST.
- Reset values: wr_ready=0 while RST high, 1 the first cycle after release; busy=0; LCD_D=5'b0; LCD_E=0; state IDLE; counter 0.
- Accept: edge where wr_valid && wr_ready. rs/data/nibble_only captured; wr_ready drops next cycle. wr_valid while not ready is ignored (no buffering, no latching).
- States: IDLE -> SETUP_H -> EHIGH_H -> HOLD_H -> SETUP_L -> EHIGH_L -> HOLD_L -> WAIT -> IDLE.
- Nibble-only: IDLE -> SETUP_L -> EHIGH_L -> HOLD_L -> WAIT (nibble = wr_data[3:0]); high-nibble states skipped.
- Each timed state lasts exactly its parameter in cycles; one shared down-counter loaded on state entry, sized $clog2(max param + 1).
- LCD_D = {rs, data[7:4]} from first SETUP_H cycle; {rs, data[3:0]} from first SETUP_L cycle; LCD_D never changes while LCD_E=1 or during HOLD.
- LCD_E=1 only in EHIGH_* states; registered, glitch-free.
- WAIT length: LONG_DELAY_CYC if nibble_only, or rs=0 and data ∈ {0x01, 0x02, 0x03}; else CMD_DELAY_CYC.
- Transaction length T (acceptance edge to wr_ready high again): full byte = 2*(SETUP+E_HIGH+HOLD)+delay; nibble = SETUP+E_HIGH+HOLD+delay. Defaults: normal byte 2654, clear 82154, nibble 82077.
- After completion LCD_D keeps last value, LCD_E=0.
- Back-to-back: wr_valid held high gives the next acceptance on the first cycle wr_ready=1; no extra idle cycle.
- RST mid-transaction: next edge IDLE, LCD_E=0, LCD_D=0, transaction dropped. No partial E pulse is extended.

Decomposition:
- Shared package lcd_pkg: state enum, LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, default timing constants, LCD_D bit-index constants (RS_BIT=4).
- No sub-module. Counter and FSM are inline; block is about 150–200 lines.

Test Plan:
- Reset: hold RST 3 cycles -> LCD_E=0, LCD_D=0, wr_ready=0, busy=0. Release -> wr_ready=1 next cycle.
- Data write rs=1, data=0x48 ('H') -> LCD_D=5'h14 for SETUP+E_HIGH+HOLD, then 5'h18. Two E pulses of exactly 25 cycles each. wr_ready returns 2654 cycles after acceptance.
- Command 0x01, rs=0 -> LCD_D 5'h00 then 5'h01. WAIT = 82000 cycles, total 82154. Command 0x28 -> total 2654.
- Nibble-only 0x03 -> one E pulse with LCD_D=5'h03, total 82077 cycles. wr_valid pulsed during busy -> ignored, no extra E pulse.
- Back-to-back "Hi": wr_valid held high -> second acceptance on the first cycle wr_ready=1. E count = 4. LCD_D stable throughout every E-high window (assertion).
- RST asserted during EHIGH_L of a data write -> next cycle LCD_E=0, LCD_D=0. After release, a new write completes normally.
